// File: rtl/lpc_pkg.sv
// lpc_pkg: shared direction codes, bridge state encoding, default bases and address helper
package lpc_pkg;
  localparam logic LPC_DIR_READ  = 1'b0;
  localparam logic LPC_DIR_WRITE = 1'b1;
  localparam logic [31:0] IMEM_BASE_DEF = 32'h0000_0000;
  localparam logic [31:0] DMEM_BASE_DEF = 32'h0001_0000;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_LO = 3'd1,
    WAIT_LO  = 3'd2,
    ISSUE_HI = 3'd3,
    WAIT_HI  = 3'd4,
    RESP     = 3'd5
  } state_e;
  function automatic logic [31:0] byte_addr(input logic [31:0] base, input logic [15:0] word_addr);
    return base + {15'b0, word_addr, 1'b0};
  endfunction
endpackage

// File: rtl/lpc_watchdog.sv
// lpc_watchdog: clear/enable cycle counter that flags the last allowed wait cycle
module lpc_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt_q, cnt_d;
  // expired marks the cycle whose increment would reach TIMEOUT
  assign expired = en && (cnt_q == W'(TIMEOUT - 1));
  always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/lpc_mem_bridge.sv
// lpc_mem_bridge: arbitrates fetch/data word requests into low/high byte LPC host cycles
module lpc_mem_bridge
  import lpc_pkg::*;
#(
  parameter logic [31:0] IMEM_BASE = IMEM_BASE_DEF,
  parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEF,
  parameter int          TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [15:0] dm_addr,
  input  logic [15:0] dm_wdata,
  output logic [15:0] dm_rdata,
  output logic        dm_ack,
  output logic        err,
  output logic        lpc_go,
  output logic        lpc_dir,
  output logic [31:0] lpc_addr,
  output logic [7:0]  lpc_wdata,
  input  logic [7:0]  lpc_rdata,
  input  logic        lpc_done
);
  state_e      state_q, state_d;
  logic        is_dm_q, is_dm_d;
  logic        dir_q, dir_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  wlo_q, wlo_d;
  logic [7:0]  whi_q, whi_d;
  logic [15:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        waiting, expired;

  assign waiting   = (state_q == WAIT_LO) || (state_q == WAIT_HI);
  assign lpc_go    = (state_q == ISSUE_LO) || (state_q == ISSUE_HI);
  assign lpc_dir   = dir_q;
  assign lpc_addr  = addr_q;
  assign lpc_wdata = wlo_q;
  assign if_ack    = (state_q == RESP) && !is_dm_q;
  assign dm_ack    = (state_q == RESP) && is_dm_q;
  assign err       = (state_q == RESP) && err_q;
  assign if_rdata  = if_ack ? rdata_q : 16'h0000;
  assign dm_rdata  = dm_ack ? rdata_q : 16'h0000;

  lpc_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (lpc_go),
    .en      (waiting),
    .expired (expired)
  );

  // wlo_q is the byte currently on the bus; whi_q holds the next one until WAIT_LO completes
  always_comb begin
    state_d = state_q;
    is_dm_d = is_dm_q;
    dir_d   = dir_q;
    addr_d  = addr_q;
    wlo_d   = wlo_q;
    whi_d   = whi_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (dm_req || if_req) begin
        state_d = ISSUE_LO;
        is_dm_d = dm_req;
        dir_d   = (dm_req && dm_we) ? LPC_DIR_WRITE : LPC_DIR_READ;
        addr_d  = dm_req ? byte_addr(DMEM_BASE, dm_addr) : byte_addr(IMEM_BASE, if_addr);
        wlo_d   = (dm_req && dm_we) ? dm_wdata[7:0] : 8'h00;
        whi_d   = (dm_req && dm_we) ? dm_wdata[15:8] : 8'h00;
        rdata_d = 16'h0000;
        err_d   = 1'b0;
      end
      ISSUE_LO: state_d = WAIT_LO;
      WAIT_LO: if (lpc_done) begin
        state_d      = ISSUE_HI;
        rdata_d[7:0] = (dir_q == LPC_DIR_READ) ? lpc_rdata : 8'h00;
        addr_d       = addr_q + 32'd1;
        wlo_d        = whi_q;
      end else if (expired) begin
        state_d = RESP;
        rdata_d = 16'hFFFF;
        err_d   = 1'b1;
      end
      ISSUE_HI: state_d = WAIT_HI;
      WAIT_HI: if (lpc_done) begin
        state_d       = RESP;
        rdata_d[15:8] = (dir_q == LPC_DIR_READ) ? lpc_rdata : 8'h00;
      end else if (expired) begin
        state_d = RESP;
        rdata_d = 16'hFFFF;
        err_d   = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      is_dm_q <= 1'b0;
      dir_q   <= LPC_DIR_READ;
      addr_q  <= 32'h0;
      wlo_q   <= 8'h00;
      whi_q   <= 8'h00;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is_dm_q <= is_dm_d;
      dir_q   <= dir_d;
      addr_q  <= addr_d;
      wlo_q   <= wlo_d;
      whi_q   <= whi_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
endmodule

// File: tb/tb_lpc_mem_bridge.sv
// tb_lpc_mem_bridge: scoreboard bench with a behavioural LPC host and word-level expectations
module tb_lpc_mem_bridge;
  localparam int          TO = 8;
  localparam logic [31:0] IB = 32'h0000_0000;
  localparam logic [31:0] DB = 32'h0001_0000;

  logic        clk, rst_n;
  logic        if_req, if_ack, dm_req, dm_we, dm_ack, err;
  logic [15:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        lpc_go, lpc_dir, lpc_done;
  logic [31:0] lpc_addr;
  logic [7:0]  lpc_wdata, lpc_rdata;

  lpc_mem_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .err(err),
    .lpc_go(lpc_go), .lpc_dir(lpc_dir), .lpc_addr(lpc_addr), .lpc_wdata(lpc_wdata),
    .lpc_rdata(lpc_rdata), .lpc_done(lpc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // d = host reply delay in cycles after go (0 = never); late = send a stray done after the timeout
  typedef struct {logic dir; logic [31:0] addr; logic [7:0] wb; logic [7:0] rb; int d; bit late;} cmd_t;
  typedef struct {bit dm; logic [15:0] rdata; bit err;} rsp_t;
  cmd_t cq[$];
  rsp_t rq[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_access(input bit dm, input bit we, input logic [15:0] a, input logic [15:0] wd,
                               input int dlo, input int dhi, input logic [7:0] rlo, input logic [7:0] rhi,
                               input bit late, input bit acked);
    cmd_t c;
    rsp_t r;
    bit w = dm && we;
    bit tmo = (dlo == 0) || (dhi == 0);
    logic [31:0] ba = (dm ? DB : IB) + 32'(a) * 32'd2;
    c.dir = w; c.addr = ba; c.wb = w ? wd[7:0] : 8'h00; c.rb = rlo; c.d = dlo; c.late = late;
    cq.push_back(c);
    if (dlo != 0) begin
      c.addr = ba + 32'd1; c.wb = w ? wd[15:8] : 8'h00; c.rb = rhi; c.d = dhi;
      cq.push_back(c);
    end
    r.dm = dm; r.err = tmo;
    r.rdata = tmo ? 16'hFFFF : w ? 16'h0000 : {rhi, rlo};
    if (acked) rq.push_back(r);
  endtask

  task automatic run_port(input bit dm, input bit we, input logic [15:0] a, input logic [15:0] wd, input bit drop);
    if (dm) begin dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1; end
    else begin if_addr = a; if_req = 1'b1; end
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (dm ? dm_ack : if_ack) begin
        if (dm) dm_req = 1'b0; else if_req = 1'b0;
        return;
      end
      if (drop && t == 1) begin
        if (dm) dm_req = 1'b0; else if_req = 1'b0;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL ack wait: no ack within 100 cycles, required one (port dm=%0d)", dm);
    if (dm) dm_req = 1'b0; else if_req = 1'b0;
  endtask

  function automatic int rand_delay();
    int r = int'($urandom_range(0, 19));
    return (r == 0) ? 0 : (r == 1) ? TO : int'($urandom_range(1, 3));
  endfunction

  function automatic logic [15:0] rand_addr();
    int r = int'($urandom_range(0, 3));
    return (r == 0) ? 16'hFFFF : (r == 1) ? 16'h0000 : 16'($urandom);
  endfunction

  // behavioural host: checks each go against the queued command, replies after d cycles
  initial begin
    cmd_t c;
    int eff;
    lpc_done = 1'b0;
    lpc_rdata = 8'h00;
    forever begin
      @(negedge clk);
      lpc_done = 1'b0;
      if (lpc_go === 1'b1) begin
        if (cq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL lpc_go: unexpected go at addr %h, required none", lpc_addr);
        end else begin
          c = cq.pop_front();
          chk("lpc_dir", 32'(lpc_dir), 32'(c.dir));
          chk("lpc_addr", lpc_addr, c.addr);
          if (c.dir) chk("lpc_wdata", 32'(lpc_wdata), 32'(c.wb));
          eff = (c.d != 0) ? c.d : c.late ? TO + 1 : 0;
          if (eff > 0) begin
            for (int k = 1; k < eff; k++) begin
              @(negedge clk);
              chk("lpc_addr stable", lpc_addr, c.addr);
            end
            @(negedge clk);
            lpc_done = 1'b1;
            lpc_rdata = c.rb;
          end
        end
      end
    end
  end

  // monitor: pops the expected response whenever an ack appears
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk);
      if (err === 1'b1 && !(if_ack || dm_ack)) begin
        n_cmp++; n_bad++;
        $display("FAIL err: err high without ack, required low");
      end
      if (if_ack === 1'b1 || dm_ack === 1'b1) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL ack: unexpected ack if=%b dm=%b, required none", if_ack, dm_ack);
        end else begin
          r = rq.pop_front();
          chk("ack port", 32'(dm_ack), 32'(r.dm));
          chk("single ack", 32'(if_ack & dm_ack), 32'd0);
          chk("rdata", 32'(r.dm ? dm_rdata : if_rdata), 32'(r.rdata));
          chk("err", 32'(err), 32'(r.err));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global timeout: simulation still running, required finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    #1;
    chk("reset lpc_go", 32'(lpc_go), 0);
    chk("reset lpc_addr", lpc_addr, 0);
    chk("reset lpc_dir", 32'(lpc_dir), 0);
    chk("reset lpc_wdata", 32'(lpc_wdata), 0);
    chk("reset if_ack", 32'(if_ack), 0);
    chk("reset dm_ack", 32'(dm_ack), 0);
    chk("reset err", 32'(err), 0);
    chk("reset rdata", 32'({if_rdata, dm_rdata}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    expect_access(0, 0, 16'h0010, 16'h0, 1, 1, 8'h34, 8'h12, 0, 1);
    run_port(0, 0, 16'h0010, 16'h0, 0);
    expect_access(1, 1, 16'h0003, 16'hBEEF, 1, 1, 8'h00, 8'h00, 0, 1);
    run_port(1, 1, 16'h0003, 16'hBEEF, 0);

    expect_access(1, 0, 16'h0100, 16'h0, 2, 1, 8'h5A, 8'hC3, 0, 1);
    expect_access(0, 0, 16'h0200, 16'h0, 1, 2, 8'h11, 8'h22, 0, 1);
    fork
      run_port(1, 0, 16'h0100, 16'h0, 0);
      run_port(0, 0, 16'h0200, 16'h0, 0);
    join

    expect_access(0, 0, 16'h0040, 16'h0, 0, 1, 8'h00, 8'h00, 0, 1);
    run_port(0, 0, 16'h0040, 16'h0, 0);
    expect_access(1, 1, 16'h0041, 16'h1234, TO, 0, 8'h00, 8'h00, 1, 1);
    run_port(1, 1, 16'h0041, 16'h1234, 0);

    expect_access(0, 0, 16'hFFFF, 16'h0, 1, 1, 8'h78, 8'h56, 0, 1);
    run_port(0, 0, 16'hFFFF, 16'h0, 0);

    // reset while waiting for the high byte: neither ack nor err may follow
    expect_access(0, 0, 16'h1234, 16'h0, 2, 0, 8'hAA, 8'h00, 0, 0);
    if_addr = 16'h1234; if_req = 1'b1;
    for (int t = 0; t < 50 && cq.size() != 0; t++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("pre-reset lpc_addr", lpc_addr, IB + 32'h2469);
    rst_n = 1'b0;
    #1;
    chk("abort lpc_addr", lpc_addr, 0);
    chk("abort lpc_go", 32'(lpc_go), 0);
    chk("abort ack", 32'({if_ack, dm_ack, err}), 0);
    if_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    expect_access(0, 0, 16'h0007, 16'h0, 1, 1, 8'h9A, 8'hBC, 0, 1);
    run_port(0, 0, 16'h0007, 16'h0, 0);

    for (int i = 0; i < 150; i++) begin
      int kind = int'($urandom_range(0, 9));
      logic [15:0] a1 = rand_addr(), a2 = rand_addr(), wd = 16'($urandom);
      bit we = 1'($urandom);
      int dl = rand_delay(), dh = rand_delay();
      logic [7:0] rl = 8'($urandom), rh = 8'($urandom);
      bit late = 1'($urandom);
      if (kind < 2) begin
        expect_access(1, we, a1, wd, dl, dh, rl, rh, late, 1);
        expect_access(0, 0, a2, 16'h0, rand_delay(), rand_delay(), 8'($urandom), 8'($urandom), 1'($urandom), 1);
        fork
          run_port(1, we, a1, wd, 0);
          run_port(0, 0, a2, 16'h0, 0);
        join
      end else begin
        bit dm = 1'($urandom);
        expect_access(dm, we, a1, wd, dl, dh, rl, rh, late, 1);
        run_port(dm, we, a1, wd, $urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("responses drained", rq.size(), 0);
    chk("commands drained", cq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
